// File: rtl/fpu_pkg.sv
// Shared FP scheduling definitions: fused-op encodings, sign-bit position,
// the per-slot requester tag and the scheduler state type.
package fpu_pkg;

    // Fused multiply-add op encodings
    localparam logic [1:0] OP_MADD  = 2'b00;  //  a*b + c
    localparam logic [1:0] OP_MSUB  = 2'b01;  //  a*b - c
    localparam logic [1:0] OP_NMSUB = 2'b10;  // -(a*b) + c
    localparam logic [1:0] OP_NMADD = 2'b11;  // -(a*b) - c

    localparam int unsigned SIGN_BIT = 31;

    // Tag index is sized for the largest supported requester count
    localparam int unsigned NREQ_MAX = 8;
    localparam int unsigned IDX_W    = $clog2(NREQ_MAX);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] index;
    } tag_t;

    typedef enum logic [1:0] {
        StReset = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2
    } sched_state_t;

    // Product is negated by flipping the sign of a
    function automatic logic neg_prod(input logic [1:0] op);
        return (op == OP_NMSUB) || (op == OP_NMADD);
    endfunction

    // Addend is negated by flipping the sign of c
    function automatic logic neg_addend(input logic [1:0] op);
        return (op == OP_MSUB) || (op == OP_NMADD);
    endfunction

    function automatic logic [31:0] flip_sign(input logic [31:0] v, input logic f);
        logic [31:0] r;
        r           = v;
        r[SIGN_BIT] = v[SIGN_BIT] ^ f;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping modulo NREQ, and returns the pointer to use after that grant.
module rr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    input  logic             i_block,
    output logic [NREQ-1:0]  o_grant,
    output logic [PTR_W-1:0] o_ptr_next
);

    localparam int N = int'(NREQ);

    int w_best_d;
    int w_best_i;
    int w_dist;

    // Pick the pending requester with the smallest rotated distance from the pointer
    always_comb begin
        w_best_d   = N;
        w_best_i   = 0;
        w_dist     = 0;
        o_grant    = '0;
        o_ptr_next = i_ptr;
        for (int i = 0; i < N; i++) begin
            w_dist = (i + N - int'(i_ptr)) % N;
            if (i_req[i] && (w_dist < w_best_d)) begin
                w_best_d = w_dist;
                w_best_i = i;
            end
        end
        if (!i_block && (w_best_d < N)) begin
            for (int i = 0; i < N; i++) begin
                if (i == w_best_i) o_grant[i] = 1'b1;
            end
            o_ptr_next = PTR_W'((w_best_i + 1) % N);
        end
    end

endmodule

// File: rtl/fma_sched.sv
// Round-robin scheduler sharing one pipelined FP multiply-add datapath
// between NREQ requesters. Op selection is done by operand sign flips; a
// tag pipe of LAT+1 {valid, index} slots routes each result to its owner.
// Optional statistics counters are built when FMA_SCHED_STATS_EN is defined.
module fma_sched
    import fpu_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned LAT  = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [2*NREQ-1:0]    i_req_op,
    input  logic [32*NREQ-1:0]   i_req_a,
    input  logic [32*NREQ-1:0]   i_req_b,
    input  logic [32*NREQ-1:0]   i_req_c,
    input  logic                 i_flush,
    output logic                 o_dp_en,
    output logic [31:0]          o_dp_a,
    output logic [31:0]          o_dp_b,
    output logic [31:0]          o_dp_c,
    input  logic [31:0]          i_dp_result,
    output logic [NREQ-1:0]      o_rsp_valid,
    output logic [31:0]          o_rsp_data
`ifdef FMA_SCHED_STATS_EN
    ,
    output logic [31:0]          o_issue_cnt,
    output logic [15:0]          o_drop_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(NREQ);

    sched_state_t     r_state;
    logic             r_dp_en;
    logic [PTR_W-1:0] r_ptr;
    logic [31:0]      r_dp_a;
    logic [31:0]      r_dp_b;
    logic [31:0]      r_dp_c;
    tag_t             r_tag [0:LAT];

    logic             w_block;
    logic [NREQ-1:0]  w_grant;
    logic [PTR_W-1:0] w_ptr_next;
    logic             w_hs;
    logic [IDX_W-1:0] w_gidx;
    logic [1:0]       w_sel_op;
    logic [31:0]      w_sel_a;
    logic [31:0]      w_sel_b;
    logic [31:0]      w_sel_c;

    // No grants outside RUN, and a flush request overrides any pending grant
    assign w_block = (r_state != StRun) | i_flush;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .i_req      (i_req_valid),
        .i_ptr      (r_ptr),
        .i_block    (w_block),
        .o_grant    (w_grant),
        .o_ptr_next (w_ptr_next)
    );

    assign o_req_ready = w_grant;
    assign w_hs        = |(i_req_valid & w_grant);

    // Mux the granted requester's op and operands
    always_comb begin
        w_gidx   = '0;
        w_sel_op = OP_MADD;
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_c  = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_grant[i]) begin
                w_gidx   = IDX_W'(i);
                w_sel_op = i_req_op[2*i +: 2];
                w_sel_a  = i_req_a[32*i +: 32];
                w_sel_b  = i_req_b[32*i +: 32];
                w_sel_c  = i_req_c[32*i +: 32];
            end
        end
    end

    // Scheduler FSM; dp_en stays high outside reset so the datapath pipeline keeps flowing
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= StReset;
            r_dp_en <= 1'b0;
        end else begin
            r_dp_en <= 1'b1;
            unique case (r_state)
                StReset: r_state <= StRun;
                StRun:   r_state <= i_flush ? StFlush : StRun;
                StFlush: r_state <= StRun;
                default: r_state <= StReset;
            endcase
        end
    end

    // Round-robin pointer advances only on a handshake
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ptr <= '0;
        end else if (w_hs) begin
            r_ptr <= w_ptr_next;
        end
    end

    // Operand registers: load sign-adjusted operands on handshake, otherwise hold
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_dp_a <= '0;
            r_dp_b <= '0;
            r_dp_c <= '0;
        end else if (w_hs) begin
            r_dp_a <= flip_sign(w_sel_a, neg_prod(w_sel_op));
            r_dp_b <= w_sel_b;
            r_dp_c <= flip_sign(w_sel_c, neg_addend(w_sel_op));
        end
    end

    // Tag pipe shifts every cycle; flush invalidates every slot at the same edge
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int unsigned k = 0; k <= LAT; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0].valid <= w_hs;
            r_tag[0].index <= w_gidx;
            for (int unsigned k = 1; k <= LAT; k++) begin
                r_tag[k].valid <= r_tag[k-1].valid & ~i_flush;
                r_tag[k].index <= r_tag[k-1].index;
            end
        end
    end

    // Decode the last tag slot into a one-hot response strobe
    always_comb begin
        o_rsp_valid = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            o_rsp_valid[i] = r_tag[LAT].valid && (r_tag[LAT].index == IDX_W'(i));
        end
    end

    assign o_dp_en    = r_dp_en;
    assign o_dp_a     = r_dp_a;
    assign o_dp_b     = r_dp_b;
    assign o_dp_c     = r_dp_c;
    assign o_rsp_data = i_dp_result;

`ifdef FMA_SCHED_STATS_EN
    logic [31:0] r_issue_cnt;
    logic [15:0] r_drop_cnt;
    logic [15:0] w_drop_n;
    logic [16:0] w_drop_sum;

    // Ops lost to a flush are those in slots 0..LAT-1; the last slot is delivered this cycle
    always_comb begin
        w_drop_n = '0;
        for (int unsigned k = 0; k < LAT; k++) begin
            w_drop_n = w_drop_n + 16'(r_tag[k].valid);
        end
        w_drop_sum = {1'b0, r_drop_cnt} + {1'b0, w_drop_n};
    end

    // Wrapping issue counter and saturating drop counter
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_issue_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_issue_cnt <= r_issue_cnt + 32'(w_hs);
            if (i_flush) begin
                r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            end
        end
    end

    assign o_issue_cnt = r_issue_cnt;
    assign o_drop_cnt  = r_drop_cnt;
`endif

endmodule
